// File: rtl/data_mem_responder_pkg.sv
// data_mem_responder_pkg: shared state encoding and data-memory constants
package data_mem_responder_pkg;
    localparam int WORD_W = 32;
    localparam int unsigned DMEM_BASE_ADDR = 32'd1024;
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;
endpackage

// File: rtl/data_mem_responder_dmem_array.sv
// dmem_array: single-port synchronous RAM with registered read
module dmem_array #(
    parameter int DEPTH = 64,
    parameter int W = 32,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] rdata_q;
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata_q <= mem[addr];
    end
    assign rdata = rdata_q;
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: wait-stated data-memory responder for the MEM-stage load/store port
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned WAIT_STATES = 2,
    parameter int unsigned BASE_ADDR = DMEM_BASE_ADDR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MEM_R_EN,
    input  logic              MEM_W_EN,
    input  logic [WORD_W-1:0] address,
    input  logic [WORD_W-1:0] write_data,
    output logic [WORD_W-1:0] read_data,
    output logic              ready,
    output logic              addr_err
);
    localparam int AW = $clog2(DEPTH_WORDS);
    state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [WORD_W-1:0] addr_q, addr_d, wdata_q, wdata_d, read_data_q, read_data_d;
    logic [WORD_W-1:0] cur_addr, cur_wdata, idx, rdata;
    logic re_q, re_d, we_q, we_d, err_q, err_d;
    logic idle, req, cur_we, cur_err, commit;
    always_comb begin
        idle = state_q == IDLE;
        req = MEM_R_EN | MEM_W_EN;
        cur_addr = idle ? address : addr_q;
        cur_wdata = idle ? write_data : wdata_q;
        cur_we = idle ? MEM_W_EN : we_q;
        idx = (cur_addr - BASE_ADDR) >> 2;
        cur_err = idle ? (address[1:0] != 2'b00 || address < BASE_ADDR || idx >= DEPTH_WORDS
                          || (MEM_R_EN & MEM_W_EN)) : err_q;
        state_d = state_q;
        cnt_d = cnt_q;
        addr_d = addr_q;
        wdata_d = wdata_q;
        re_d = re_q;
        we_d = we_q;
        err_d = err_q;
        if (idle && req) begin
            addr_d = address;
            wdata_d = write_data;
            re_d = MEM_R_EN;
            we_d = MEM_W_EN;
            err_d = cur_err;
            cnt_d = 4'(WAIT_STATES);
            state_d = (WAIT_STATES == 0) ? DONE : BUSY;
        end else if (state_q == BUSY) begin
            cnt_d = cnt_q - 4'd1;
            state_d = (cnt_q == 4'd1) ? DONE : BUSY;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
        // RAM commits on the edge entering DONE, so its registered read lands in the DONE cycle
        commit = state_q != DONE && state_d == DONE;
        ready = idle ? ~req : state_q == DONE;
        addr_err = state_q == DONE && err_q;
        read_data = (state_q == DONE && re_q) ? (err_q ? '0 : rdata) : read_data_q;
        read_data_d = read_data;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            addr_q <= '0;
            wdata_q <= '0;
            read_data_q <= '0;
            re_q <= 1'b0;
            we_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            addr_q <= addr_d;
            wdata_q <= wdata_d;
            read_data_q <= read_data_d;
            re_q <= re_d;
            we_q <= we_d;
            err_q <= err_d;
        end
    end
    dmem_array #(.DEPTH(DEPTH_WORDS), .W(WORD_W)) u_array (
        .clk  (clk),
        .we   (commit & cur_we & ~cur_err & ~rst),
        .addr (idx[AW-1:0]),
        .wdata(cur_wdata),
        .rdata(rdata)
    );
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: scoreboard bench for the wait-stated data-memory responder
module tb_data_mem_responder;
    typedef struct {
        logic        rd;
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic clk = 0, rst = 1, sel = 0, mon_en = 0;
    logic r_en = 0, w_en = 0;
    logic [31:0] addr = 0, wdata = 0;
    logic [31:0] rd2, rd0, rd_m;
    logic rdy2, rdy0, err2, err0, rdy_m, err_m;
    exp_t sb_q[$];
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.WAIT_STATES(2)) dut (
        .clk(clk), .rst(rst), .MEM_R_EN(r_en & ~sel), .MEM_W_EN(w_en & ~sel),
        .address(addr), .write_data(wdata), .read_data(rd2), .ready(rdy2), .addr_err(err2)
    );
    data_mem_responder #(.WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .MEM_R_EN(r_en & sel), .MEM_W_EN(w_en & sel),
        .address(addr), .write_data(wdata), .read_data(rd0), .ready(rdy0), .addr_err(err0)
    );

    assign rd_m = sel ? rd0 : rd2;
    assign rdy_m = sel ? rdy0 : rdy2;
    assign err_m = sel ? err0 : err2;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // Monitor: a DONE cycle is ready=1 while the requester still holds its request
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (rdy_m && (r_en | w_en)) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("addr_err", {31'd0, err_m}, {31'd0, e.err});
                    if (e.rd) chk("read_data", rd_m, e.data);
                end
            end else begin
                chk("addr_err_idle", {31'd0, err_m}, 32'd0);
            end
        end
    end

    // Issue one access at posedge+1; returns at posedge+1 after DONE with the request dropped
    task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic e_err, input logic [31:0] e_rd, input int e_len);
        int lows;
        bit done;
        lows = 0;
        done = 0;
        sb_q.push_back('{rd: r, err: e_err, data: e_rd});
        r_en = r; w_en = w; addr = a; wdata = d;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (rdy_m) done = 1;
            else lows++;
        end
        if (!done) chk("timeout", 32'd1, 32'd0);
        chk("stall_len", lows, e_len);
        @(posedge clk); #1;
        r_en = 0; w_en = 0;
    endtask

    initial begin
        logic [7:0] pat;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_ready", {31'd0, rdy2}, 32'd1);
        chk("rst_read_data", rd2, 32'd0);
        chk("rst_addr_err", {31'd0, err2}, 32'd0);
        chk("rst_ready0", {31'd0, rdy0}, 32'd1);
        mon_en = 1;
        @(posedge clk); #1;
        // 1: store then load
        access(0, 1, 1024, 32'hDEADBEEF, 0, 0, 3);
        access(1, 0, 1024, 0, 0, 32'hDEADBEEF, 3);
        @(negedge clk);
        chk("read_hold", rd2, 32'hDEADBEEF);
        chk("idle_ready", {31'd0, rdy2}, 32'd1);
        @(posedge clk); #1;
        // 2: error accesses and the last valid word
        access(1, 0, 1026, 0, 1, 0, 3);
        access(1, 0, 1020, 0, 1, 0, 3);
        access(0, 1, 1280, 32'h55555555, 1, 0, 3);
        access(1, 0, 1024, 0, 0, 32'hDEADBEEF, 3);
        access(0, 1, 1276, 32'h0BADF00D, 0, 0, 3);
        access(1, 0, 1276, 0, 0, 32'h0BADF00D, 3);
        // 3: conflicting read+write
        access(0, 1, 1028, 32'h11112222, 0, 0, 3);
        access(1, 1, 1028, 32'hFFFFFFFF, 1, 0, 3);
        access(1, 0, 1028, 0, 0, 32'h11112222, 3);
        // 4: request held through DONE becomes exactly two accesses
        sb_q.push_back('{rd: 1, err: 0, data: 32'hDEADBEEF});
        sb_q.push_back('{rd: 1, err: 0, data: 32'hDEADBEEF});
        r_en = 1; addr = 1024;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            pat[i] = rdy2;
        end
        @(posedge clk); #1;
        r_en = 0;
        chk("ready_pattern", {24'd0, pat}, 32'h88);
        // 5: reset during BUSY abandons the store
        access(0, 1, 1032, 32'hAAAA5555, 0, 0, 3);
        access(1, 0, 1032, 0, 0, 32'hAAAA5555, 3);
        w_en = 1; addr = 1032; wdata = 32'h12345678;
        @(posedge clk); #1;
        rst = 1; w_en = 0;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("abort_ready", {31'd0, rdy2}, 32'd1);
        chk("abort_read_data", rd2, 32'd0);
        chk("abort_addr_err", {31'd0, err2}, 32'd0);
        @(posedge clk); #1;
        access(1, 0, 1032, 0, 0, 32'hAAAA5555, 3);
        // 6: zero wait states
        sel = 1;
        access(0, 1, 1100, 32'hCAFEF00D, 0, 0, 1);
        access(1, 0, 1100, 0, 0, 32'hCAFEF00D, 1);
        access(1, 0, 1101, 0, 1, 0, 1);
        repeat (2) @(posedge clk);
        chk("scoreboard_empty", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
